// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI packet receiver.
package spi_pkg;

    localparam int BYTE_W     = 8;
    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        RECV
    } rx_state_t;

endpackage

// File: rtl/spi_packet_rx_sync_ff.sv
// N-stage single-bit synchronizer with a
// configurable synchronous reset value.
module sync_ff #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= {DEPTH{RST_VAL}};
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/spi_packet_rx.sv
// Oversampling SPI mode-0 receiver delivering
// two-byte frames to the packet decoder.
module spi_packet_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = spi_pkg::FRAME_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              sdi,
    input  logic              cs_n,
    output logic [BYTE_W-1:0] spiPacket1,
    output logic [BYTE_W-1:0] spiPacket2,
    output logic              ready,
    output logic              frameError,
    output logic              busy
);

    localparam int SHIFT_W = 2 * BYTE_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
    // Synchronizers reset cs_n high; wait until that value has flushed
    localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SYNC_STAGES + 3);

    logic cs_s, sck_s, sdi_s;
    logic cs_d, sck_d;
    logic cs_q, sdi_q;
    logic sck_rise, cs_rise, cs_fall;

    rx_state_t          state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [SHIFT_W-1:0] shift, shift_n;
    logic [BYTE_W-1:0]  p1_n, p2_n;
    logic               ready_n, err_n;

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d(cs_n), .q(cs_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .reset(reset), .d(sck), .q(sck_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .reset(reset), .d(sdi), .q(sdi_s)
    );

    // Registered edge flags keep sdi aligned with the sck event
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_d     <= 1'b1;
            sck_d    <= 1'b0;
            cs_q     <= 1'b0;
            sdi_q    <= 1'b0;
            sck_rise <= 1'b0;
            cs_rise  <= 1'b0;
            cs_fall  <= 1'b0;
        end else begin
            cs_d     <= cs_s;
            sck_d    <= sck_s;
            cs_q     <= cs_s;
            sdi_q    <= sdi_s;
            sck_rise <= sck_s & ~sck_d;
            cs_rise  <= cs_s & ~cs_d;
            cs_fall  <= ~cs_s & cs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_IDLE;
            cnt        <= '0;
            shift      <= '0;
            spiPacket1 <= '0;
            spiPacket2 <= '0;
            ready      <= 1'b0;
            frameError <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shift      <= shift_n;
            spiPacket1 <= p1_n;
            spiPacket2 <= p2_n;
            ready      <= ready_n;
            frameError <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shift_n = shift;
        p1_n    = spiPacket1;
        p2_n    = spiPacket2;
        ready_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (cnt != CNT_MAX) begin
                    cnt_n = cnt + 1'b1;
                end
                if (cs_q && cnt >= SETTLE) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    state_n = RECV;
                    cnt_n   = '0;
                    shift_n = '0;
                end
            end
            RECV: begin
                if (cs_rise) begin
                    state_n = IDLE;
                    if (cnt == CNT_FRAME) begin
                        p1_n    = shift[SHIFT_W-1:BYTE_W];
                        p2_n    = shift[BYTE_W-1:0];
                        ready_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (sck_rise && !cs_q) begin
                    shift_n = {shift[SHIFT_W-2:0], sdi_q};
                    if (cnt != CNT_MAX) begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = WAIT_IDLE;
            end
        endcase
    end

    assign busy = (state == RECV);

endmodule

// File: tb/tb_spi_packet_rx.sv
// Directed self-checking bench for spi_packet_rx.
module tb_spi_packet_rx;

    logic       clk;
    logic       reset;
    logic       sck;
    logic       sdi;
    logic       cs_n;
    logic [7:0] spiPacket1;
    logic [7:0] spiPacket2;
    logic       ready;
    logic       frameError;
    logic       busy;

    int checks;
    int errors;
    int ready_cnt;
    int err_cnt;
    int both_cnt;
    logic [15:0] caps[$];

    spi_packet_rx #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
        .clk(clk),
        .reset(reset),
        .sck(sck),
        .sdi(sdi),
        .cs_n(cs_n),
        .spiPacket1(spiPacket1),
        .spiPacket2(spiPacket2),
        .ready(ready),
        .frameError(frameError),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (ready) begin
            ready_cnt++;
            caps.push_back({spiPacket1, spiPacket2});
        end
        if (frameError) err_cnt++;
        if (ready && frameError) both_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdi = data[i];
            wait_clk(3);
            sck = 1'b1;
            wait_clk(3);
            sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] data, input int n);
        cs_n = 1'b0;
        wait_clk(3);
        send_bits(data, n);
        wait_clk(3);
        cs_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_clk(3);
        chk("rst_p1", 32'(spiPacket1), 32'h0);
        chk("rst_p2", 32'(spiPacket2), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_err", 32'(frameError), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        wait_clk(2);
        chk("post_rst_busy", 32'(busy), 32'h0);
    endtask

    task automatic test_startup;
        int r0, e0;
        r0 = ready_cnt;
        e0 = err_cnt;
        send_bits(32'hFFFF, 16);
        chk("start_busy", 32'(busy), 32'h0);
        wait_clk(3);
        cs_n = 1'b1;
        wait_clk(10);
        chk("start_ready", 32'(ready_cnt - r0), 32'h0);
        chk("start_err", 32'(err_cnt - e0), 32'h0);
        chk("start_p1", 32'(spiPacket1), 32'h0);
        chk("start_p2", 32'(spiPacket2), 32'h0);
    endtask

    task automatic test_valid;
        int r0, e0, lat;
        r0 = ready_cnt;
        e0 = err_cnt;
        lat = 0;
        cs_n = 1'b0;
        wait_clk(3);
        send_bits(32'h1234, 16);
        chk("valid_busy", 32'(busy), 32'h1);
        wait_clk(3);
        cs_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (ready && lat == 0) lat = c;
        end
        chk("valid_latency", 32'(lat), 32'd4);
        chk("valid_ready", 32'(ready_cnt - r0), 32'h1);
        chk("valid_err", 32'(err_cnt - e0), 32'h0);
        chk("valid_p1", 32'(spiPacket1), 32'h12);
        chk("valid_p2", 32'(spiPacket2), 32'h34);
        chk("valid_busy_end", 32'(busy), 32'h0);
    endtask

    task automatic test_back_to_back;
        int r0, e0;
        r0 = ready_cnt;
        e0 = err_cnt;
        wait_clk(4);
        frame(32'hF500, 16);
        wait_clk(2);
        frame(32'h4080, 16);
        wait_clk(8);
        chk("b2b_ready", 32'(ready_cnt - r0), 32'h2);
        chk("b2b_err", 32'(err_cnt - e0), 32'h0);
        if (caps.size() >= 2) begin
            chk("b2b_first", 32'(caps[caps.size()-2]), 32'hF500);
            chk("b2b_second", 32'(caps[caps.size()-1]), 32'h4080);
        end else begin
            chk("b2b_caps", 32'(caps.size()), 32'h2);
        end
        chk("b2b_p1", 32'(spiPacket1), 32'h40);
        chk("b2b_p2", 32'(spiPacket2), 32'h80);
    endtask

    task automatic test_short;
        int r0, e0;
        frame(32'hAA55, 16);
        wait_clk(8);
        r0 = ready_cnt;
        e0 = err_cnt;
        frame(32'h1234, 15);
        wait_clk(8);
        chk("short_ready", 32'(ready_cnt - r0), 32'h0);
        chk("short_err", 32'(err_cnt - e0), 32'h1);
        chk("short_p1", 32'(spiPacket1), 32'hAA);
        chk("short_p2", 32'(spiPacket2), 32'h55);
    endtask

    task automatic test_long;
        int r0, e0;
        r0 = ready_cnt;
        e0 = err_cnt;
        frame(32'h1BEEF, 17);
        wait_clk(8);
        chk("long_ready", 32'(ready_cnt - r0), 32'h0);
        chk("long_err", 32'(err_cnt - e0), 32'h1);
        chk("long_p1", 32'(spiPacket1), 32'hAA);
        chk("long_p2", 32'(spiPacket2), 32'h55);
    endtask

    task automatic test_reset_mid;
        int r0, e0;
        r0 = ready_cnt;
        e0 = err_cnt;
        cs_n = 1'b0;
        wait_clk(3);
        send_bits(32'hC3, 8);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        send_bits(32'h3C, 8);
        wait_clk(3);
        cs_n = 1'b1;
        wait_clk(10);
        chk("rmid_ready", 32'(ready_cnt - r0), 32'h0);
        chk("rmid_err", 32'(err_cnt - e0), 32'h0);
        chk("rmid_p1", 32'(spiPacket1), 32'h0);
        chk("rmid_p2", 32'(spiPacket2), 32'h0);
        r0 = ready_cnt;
        frame(32'h0102, 16);
        wait_clk(8);
        chk("rmid_next_ready", 32'(ready_cnt - r0), 32'h1);
        chk("rmid_next_p1", 32'(spiPacket1), 32'h01);
        chk("rmid_next_p2", 32'(spiPacket2), 32'h02);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ready_cnt = 0;
        err_cnt = 0;
        both_cnt = 0;
        sck = 1'b0;
        sdi = 1'b0;
        cs_n = 1'b0;
        reset = 1'b1;
        test_reset();
        test_startup();
        wait_clk(6);
        test_valid();
        test_back_to_back();
        wait_clk(4);
        test_short();
        wait_clk(4);
        test_long();
        wait_clk(4);
        test_reset_mid();
        chk("ready_err_exclusive", 32'(both_cnt), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
